// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: IDLE -> EXEC -> RESP per operation.
// Define ALU_ARB_FIXED_PRIO_EN to make A win every tie (default: round-robin via a last-grant bit).
module alu_arbiter #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          req_b,
    input  logic [5:0]    func_a,
    input  logic [5:0]    func_b,
    input  logic [1:0]    aluop_a,
    input  logic [1:0]    aluop_b,
    input  logic [DW-1:0] op1_a,
    input  logic [DW-1:0] op2_a,
    input  logic [DW-1:0] op1_b,
    input  logic [DW-1:0] op2_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          done_a,
    output logic          done_b,
    output logic [DW-1:0] res,
    output logic          res_zero,
    output logic [5:0]    alu_instruction,
    output logic [DW-1:0] alu_data1,
    output logic [DW-1:0] alu_data2,
    output logic          alu_op1,
    output logic          alu_op2,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_pick_b;
    logic          w_latch;
    logic          w_capture;
    logic          w_done_set;
    logic          r_gnt_a;
    logic          r_gnt_b;
    logic          r_done_a;
    logic          r_done_b;
    logic          r_owner_b;
    logic [5:0]    r_func;
    logic [1:0]    r_aluop;
    logic [DW-1:0] r_op1;
    logic [DW-1:0] r_op2;
    logic [DW-1:0] r_res;
    logic          r_res_zero;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_pick_b = req_b & ~req_a;
`else
    logic r_last_b;

    // On a tie B wins only if A was granted last.
    assign w_pick_b = req_b & (~req_a | ~r_last_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_b <= 1'b1;
        end else if (w_latch) begin
            r_last_b <= w_pick_b;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_latch         = 1'b0;
        w_capture       = 1'b0;
        w_done_set      = 1'b0;
        alu_instruction = '0;
        alu_data1       = '0;
        alu_data2       = '0;
        alu_op1         = 1'b0;
        alu_op2         = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_a | req_b) begin
                    w_latch     = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                alu_instruction = r_func;
                alu_data1       = r_op1;
                alu_data2       = r_op2;
                alu_op1         = r_aluop[1];
                alu_op2         = r_aluop[0];
                w_capture       = 1'b1;
                w_state_nxt     = RESP;
            end
            RESP: begin
                w_done_set  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // gnt and done are registered, so each shows up in the cycle after the state that sets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_done_a   <= 1'b0;
            r_done_b   <= 1'b0;
            r_owner_b  <= 1'b0;
            r_func     <= '0;
            r_aluop    <= '0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_res      <= '0;
            r_res_zero <= 1'b0;
        end else begin
            r_gnt_a  <= w_latch & ~w_pick_b;
            r_gnt_b  <= w_latch & w_pick_b;
            r_done_a <= w_done_set & ~r_owner_b;
            r_done_b <= w_done_set & r_owner_b;
            if (w_latch) begin
                r_owner_b <= w_pick_b;
                r_func    <= w_pick_b ? func_b  : func_a;
                r_aluop   <= w_pick_b ? aluop_b : aluop_a;
                r_op1     <= w_pick_b ? op1_b   : op1_a;
                r_op2     <= w_pick_b ? op2_b   : op2_a;
            end
            if (w_capture) begin
                r_res      <= alu_result;
                r_res_zero <= alu_zero;
            end
        end
    end

    assign gnt_a    = r_gnt_a;
    assign gnt_b    = r_gnt_b;
    assign done_a   = r_done_a;
    assign done_b   = r_done_b;
    assign res      = r_res;
    assign res_zero = r_res_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a small MIPS-style ALU standing in for the external one.
// Tie-order expectations follow ALU_ARB_FIXED_PRIO_EN when it is defined.
module tb_alu_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_a = 1'b0, req_b = 1'b0;
    logic [5:0]    func_a = '0, func_b = '0;
    logic [1:0]    aluop_a = '0, aluop_b = '0;
    logic [DW-1:0] op1_a = '0, op2_a = '0, op1_b = '0, op2_b = '0;
    logic          gnt_a, gnt_b, done_a, done_b, res_zero;
    logic [DW-1:0] res, alu_data1, alu_data2, alu_result;
    logic [5:0]    alu_instruction;
    logic          alu_op1, alu_op2, alu_zero;

    alu_arbiter #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b),
        .func_a(func_a), .func_b(func_b),
        .aluop_a(aluop_a), .aluop_b(aluop_b),
        .op1_a(op1_a), .op2_a(op2_a), .op1_b(op1_b), .op2_b(op2_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .res(res), .res_zero(res_zero),
        .alu_instruction(alu_instruction), .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    // External combinational ALU: 00 add, 01 subtract, 1x decode funct.
    always_comb begin
        alu_result = '0;
        case ({alu_op1, alu_op2})
            2'b00: alu_result = alu_data1 + alu_data2;
            2'b01: alu_result = alu_data1 - alu_data2;
            default: begin
                case (alu_instruction)
                    6'b100000: alu_result = alu_data1 + alu_data2;
                    6'b100010: alu_result = alu_data1 - alu_data2;
                    6'b100100: alu_result = alu_data1 & alu_data2;
                    6'b100101: alu_result = alu_data1 | alu_data2;
                    6'b101010: alu_result = {31'd0, $signed(alu_data1) < $signed(alu_data2)};
                    default:   alu_result = '0;
                endcase
            end
        endcase
    end
    assign alu_zero = (alu_result == '0);

    typedef struct {
        logic          b;
        logic [5:0]    f;
        logic [1:0]    op;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [DW-1:0] r;
        logic          z;
    } exp_t;

    exp_t gq[$];
    exp_t dq[$];
    int   s_chk = 0, s_err = 0, m_chk = 0, m_err = 0;

    function automatic exp_t mk(input logic b, input logic [5:0] f, input logic [1:0] op,
                                input logic [DW-1:0] x, input logic [DW-1:0] y,
                                input logic [DW-1:0] r, input logic z);
        exp_t e;
        e.b = b; e.f = f; e.op = op; e.x = x; e.y = y; e.r = r; e.z = z;
        return e;
    endfunction

    task automatic schk(input string name, input logic ok, input logic [DW-1:0] got,
                        input logic [DW-1:0] want);
        s_chk++;
        if (!ok) begin
            s_err++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic drive(input exp_t e, input logic on);
        if (e.b) begin
            req_b = on; func_b = on ? e.f : '0; aluop_b = on ? e.op : '0;
            op1_b = on ? e.x : '0; op2_b = on ? e.y : '0;
        end else begin
            req_a = on; func_a = on ? e.f : '0; aluop_a = on ? e.op : '0;
            op1_a = on ? e.x : '0; op2_a = on ? e.y : '0;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && (dq.size() != 0 || gq.size() != 0); i++) @(negedge clk);
        schk("drain_timeout", dq.size() == 0 && gq.size() == 0, dq.size(), 0);
        @(negedge clk);
    endtask

    task automatic run_op(input exp_t e);
        logic g;
        gq.push_back(e);
        dq.push_back(e);
        @(negedge clk);
        drive(e, 1'b1);
        @(posedge clk);
        #1;
        g = e.b ? gnt_b : gnt_a;
        schk("gnt_latency", g, g, 1);
        @(negedge clk);
        drive(e, 1'b0);
        wait_drain();
    endtask

    task automatic chk_all_zero(input string name);
        schk({name, "_ctl"}, {gnt_a, gnt_b, done_a, done_b} == 4'b0, {gnt_a, gnt_b, done_a, done_b}, 0);
        schk({name, "_res"}, res == '0 && !res_zero, res, 0);
        schk({name, "_alu"}, {alu_instruction, alu_data1, alu_data2, alu_op1, alu_op2} == '0,
             alu_data1, 0);
    endtask

    // Monitor: global invariants every cycle, then pop the scoreboard on grant and done.
    initial begin
        int   cyc;
        int   gcyc;
        exp_t e;
        cyc = 0;
        gcyc = -100;
        forever begin
            @(negedge clk);
            cyc++;
            m_chk++;
            if ((gnt_a && gnt_b) || (done_a && done_b)) begin
                m_err++;
                $display("FAIL excl: gnt=%b%b done=%b%b required no pair high", gnt_a, gnt_b, done_a, done_b);
            end
            if (!(gnt_a || gnt_b)) begin
                m_chk++;
                if ({alu_instruction, alu_data1, alu_data2, alu_op1, alu_op2} != '0) begin
                    m_err++;
                    $display("FAIL alu_idle: instr=%0h d1=%0h d2=%0h op=%b%b required 0",
                             alu_instruction, alu_data1, alu_data2, alu_op1, alu_op2);
                end
            end
            if (gnt_a || gnt_b) begin
                m_chk++;
                if (gq.size() == 0) begin
                    m_err++;
                    $display("FAIL gnt_unexpected: gnt=%b%b required none", gnt_a, gnt_b);
                end else begin
                    e = gq.pop_front();
                    gcyc = cyc;
                    if (gnt_b != e.b || alu_instruction != e.f || {alu_op1, alu_op2} != e.op ||
                        alu_data1 != e.x || alu_data2 != e.y) begin
                        m_err++;
                        $display("FAIL gnt: b=%b f=%b op=%b d1=%0h d2=%0h required b=%b f=%b op=%b d1=%0h d2=%0h",
                                 gnt_b, alu_instruction, {alu_op1, alu_op2}, alu_data1, alu_data2,
                                 e.b, e.f, e.op, e.x, e.y);
                    end
                end
            end
            if (done_a || done_b) begin
                m_chk++;
                if (dq.size() == 0) begin
                    m_err++;
                    $display("FAIL done_unexpected: done=%b%b required none", done_a, done_b);
                end else begin
                    e = dq.pop_front();
                    if (done_b != e.b || res != e.r || res_zero != e.z || cyc != gcyc + 2) begin
                        m_err++;
                        $display("FAIL done: b=%b res=%0h z=%b lat=%0d required b=%b res=%0h z=%b lat=2",
                                 done_b, res, res_zero, cyc - gcyc, e.b, e.r, e.z);
                    end
                end
            end
        end
    end

    initial begin
        exp_t ea, eb;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Single-requester vectors
        run_op(mk(1'b0, 6'b100000, 2'b10, 32'd2, 32'd2, 32'd4, 1'b0));
        schk("res_hold", res == 32'd4, res, 32'd4);
        run_op(mk(1'b1, 6'b000000, 2'b01, 32'd7, 32'd7, 32'd0, 1'b1));
        run_op(mk(1'b0, 6'b100100, 2'b10, 32'hF0F0_FFFF, 32'h0FF0_00FF, 32'h00F0_00FF, 1'b0));
        run_op(mk(1'b1, 6'b101010, 2'b10, 32'd3, 32'd5, 32'd1, 1'b0));
        run_op(mk(1'b0, 6'b000000, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1));
        run_op(mk(1'b1, 6'b100101, 2'b10, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0));
        run_op(mk(1'b0, 6'b100010, 2'b10, 32'd5, 32'd9, 32'hFFFF_FFFC, 1'b0));

        // Both requesters held from reset for four operations
        ea = mk(1'b0, 6'b100000, 2'b10, 32'd1, 32'd2, 32'd3, 1'b0);
        eb = mk(1'b1, 6'b000000, 2'b01, 32'd10, 32'd4, 32'd6, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        drive(ea, 1'b1);
        drive(eb, 1'b1);
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            gq.push_back(ea); dq.push_back(ea);
`else
            if (i % 2 == 0) begin gq.push_back(ea); dq.push_back(ea); end
            else begin gq.push_back(eb); dq.push_back(eb); end
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60 && gq.size() != 0; i++) @(negedge clk);
        schk("tie_grants", gq.size() == 0, gq.size(), 0);
        drive(ea, 1'b0);
        drive(eb, 1'b0);
        wait_drain();

        // B requests while A is executing
        ea = mk(1'b0, 6'b100000, 2'b10, 32'd100, 32'd23, 32'd123, 1'b0);
        eb = mk(1'b1, 6'b000000, 2'b01, 32'd50, 32'd8, 32'd42, 1'b0);
        gq.push_back(ea); dq.push_back(ea);
        gq.push_back(eb); dq.push_back(eb);
        @(negedge clk);
        drive(ea, 1'b1);
        @(posedge clk); #1;
        schk("busy_gnt_a", gnt_a, gnt_a, 1);
        @(negedge clk);
        drive(ea, 1'b0);
        drive(eb, 1'b1);
        @(posedge clk); #1;
        schk("busy_no_gnt_b_resp", !gnt_b, gnt_b, 0);
        @(posedge clk); #1;
        schk("busy_no_gnt_b_idle", !gnt_b && done_a, {gnt_b, done_a}, 2'b01);
        @(posedge clk); #1;
        schk("busy_gnt_b", gnt_b, gnt_b, 1);
        @(negedge clk);
        drive(eb, 1'b0);
        wait_drain();

        // Reset while A is in EXEC: abort, then a normal operation
        ea = mk(1'b0, 6'b100000, 2'b10, 32'd3, 32'd4, 32'd7, 1'b0);
        gq.push_back(ea);
        @(negedge clk);
        drive(ea, 1'b1);
        @(posedge clk); #1;
        schk("abort_gnt_a", gnt_a, gnt_a, 1);
        @(negedge clk);
        drive(ea, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        schk("abort_res", res == '0 && !res_zero, res, 0);
        run_op(mk(1'b0, 6'b100000, 2'b10, 32'd20, 32'd22, 32'd42, 1'b0));

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", s_err + m_err, s_chk + m_chk);
        $finish;
    end

endmodule
